// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared stage-register state encoding, NOP control value and per-boundary widths
package cpu_pipe_pkg;
  typedef enum logic [1:0] {EMPTY, FULL, SKID} pipe_state_e;
  localparam int CTRL_NOP = 0;
  localparam int IFID_CTRL_W = 1;
  localparam int IFID_DATA_W = 64;
  localparam int IDEX_CTRL_W = 10;
  localparam int IDEX_DATA_W = 117;
  localparam int EXMEM_CTRL_W = 6;
  localparam int EXMEM_DATA_W = 101;
  localparam int MEMWB_CTRL_W = 3;
  localparam int MEMWB_DATA_W = 69;
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one valid+ctrl+data register with load, ctrl clear and full clear
module pipe_entry
  import cpu_pipe_pkg::*;
#(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 117
) (
  input  logic              clk,
  input  logic              clr_all,
  input  logic              clr_ctrl,
  input  logic              load,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);
  always_ff @(posedge clk) begin
    if (clr_all) begin
      valid <= 1'b0;
      ctrl  <= CTRL_W'(CTRL_NOP);
      data  <= '0;
    end else if (clr_ctrl) begin
      valid <= 1'b0;
      ctrl  <= CTRL_W'(CTRL_NOP);
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage register with skid entry, flush and bubble counter
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int DATA_W = IDEX_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  pipe_state_e state, state_nxt;
  logic accept, drain;
  logic main_load, main_from_skid, main_clr, skid_load, skid_clr;
  logic skid_valid;
  logic [CTRL_W-1:0] skid_ctrl, main_in_ctrl;
  logic [DATA_W-1:0] skid_data, main_in_data;
  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;
  always_ff @(posedge clk) begin
    state      <= rst ? EMPTY : state_nxt;
    in_ready   <= rst ? 1'b1 : (state_nxt != SKID);
    bubble_cnt <= rst ? '0 : (!out_valid && bubble_cnt != CNT_MAX) ? bubble_cnt + 1'b1 : bubble_cnt;
  end
  always_comb begin
    state_nxt = flush ? EMPTY :
                state == EMPTY ? (accept ? FULL : EMPTY) :
                state == FULL  ? ((accept && !drain) ? SKID : (!accept && drain) ? EMPTY : FULL) :
                                 (drain ? FULL : SKID);
  end
  // skid never receives from upstream while draining into main, so main picks one source
  always_comb begin
    main_from_skid = !flush && state == SKID && drain;
    main_load      = main_from_skid || (!flush && accept && (state == EMPTY || drain));
    main_clr       = flush || (state == FULL && drain && !accept);
    skid_load      = !flush && state == FULL && accept && !drain;
    skid_clr       = flush || (state == SKID && drain);
    main_in_ctrl   = main_from_skid ? skid_ctrl : in_ctrl;
    main_in_data   = main_from_skid ? skid_data : in_data;
  end
  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk(clk), .clr_all(rst), .clr_ctrl(main_clr), .load(main_load),
    .in_ctrl(main_in_ctrl), .in_data(main_in_data),
    .valid(out_valid), .ctrl(out_ctrl), .data(out_data)
  );
  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk(clk), .clr_all(rst), .clr_ctrl(skid_clr), .load(skid_load),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .valid(skid_valid), .ctrl(skid_ctrl), .data(skid_data)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed checks of pipe_stage_reg against a queue model
module tb_pipe_stage_reg;
  logic clk = 0;
  logic rst, flush, in_valid, out_ready;
  logic [9:0] in_ctrl;
  logic [116:0] in_data;
  logic in_ready, out_valid, s_in_ready, s_out_valid;
  logic [9:0] out_ctrl, s_out_ctrl;
  logic [116:0] out_data, s_out_data;
  logic [15:0] bubble_cnt;
  logic [3:0] s_bubble_cnt;
  typedef struct {logic [9:0] c; logic [116:0] d;} beat_t;
  beat_t q[$];
  logic m_rdy;
  int cnt, scnt, checks, errors;
  always #5 clk = ~clk;
  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .bubble_cnt(bubble_cnt)
  );
  pipe_stage_reg #(.CTRL_W(10), .DATA_W(117), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_ctrl(s_out_ctrl), .out_data(s_out_data), .bubble_cnt(s_bubble_cnt)
  );
  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_rdy = 1;
      cnt = 0;
      scnt = 0;
    end else begin
      if (q.size() == 0) begin
        if (cnt < 65535) cnt++;
        if (scnt < 15) scnt++;
      end
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_valid && m_rdy) q.push_back('{in_ctrl, in_data});
      m_rdy = q.size() < 2;
    end
    #1;
    chk("in_ready", in_ready, m_rdy);
    chk("out_valid", out_valid, q.size() > 0);
    chk("out_ctrl", out_ctrl, q.size() > 0 ? q[0].c : 10'h0);
    if (q.size() > 0) chk("out_data", out_data, q[0].d);
    chk("bubble_cnt", bubble_cnt, cnt);
    chk("s_in_ready", s_in_ready, m_rdy);
    chk("s_out_valid", s_out_valid, q.size() > 0);
    chk("s_out_ctrl", s_out_ctrl, q.size() > 0 ? q[0].c : 10'h0);
    if (q.size() > 0) chk("s_out_data", s_out_data, q[0].d);
    chk("s_bubble_cnt", s_bubble_cnt, scnt);
    if (rst) chk("rst_data", out_data, 0);
  endtask
  initial begin
    int d;
    checks = 0; errors = 0; m_rdy = 1; cnt = 0; scnt = 0;
    rst = 1; flush = 0; in_valid = 0; out_ready = 1; in_ctrl = 0; in_data = 0;
    repeat (2) step();
    rst = 0;
    repeat (2) step();
    in_ctrl = 10'h3FF;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1;
      in_data = 117'(i);
      step();
    end
    chk("stream_bubbles", bubble_cnt, 3);
    d = 9;
    for (int i = 0; i < 10; i++) begin
      logic acc;
      out_ready = !(i >= 1 && i <= 3);
      in_data = 117'(d);
      acc = m_rdy;
      step();
      if (acc) d++;
      if (i == 2) chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 0;
    in_valid = 1;
    repeat (2) begin
      in_data = 117'(d++);
      step();
    end
    chk("skid_full", in_ready, 0);
    flush = 1;
    in_data = 117'hDEAD;
    step();
    flush = 0;
    in_valid = 0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ctrl", out_ctrl, 0);
    chk("flush_ready", in_ready, 1);
    out_ready = 1;
    step();
    chk("flush_dropped", out_valid, 0);
    in_valid = 1;
    in_data = 117'hABC;
    repeat (2) step();
    rst = 1;
    step();
    rst = 0;
    chk("rst_out_data", out_data, 0);
    chk("rst_cnt", bubble_cnt, 0);
    in_valid = 0;
    repeat (20) step();
    chk("sat_cnt", s_bubble_cnt, 15);
    in_valid = 1;
    in_ctrl = 10'h011;
    in_data = 117'h44;
    step();
    in_data = 117'h55;
    step();
    chk("acc_drain_data", out_data, 117'h55);
    chk("acc_drain_ready", in_ready, 1);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(99) == 0);
      flush = ($urandom_range(19) == 0);
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_ctrl = 10'($urandom);
      in_data = 117'({$urandom, $urandom, $urandom, $urandom});
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
